// File: rtl/poker_pkg.sv
// Shared definitions for the dealer/bot action handshake: action codes,
// collector FSM states and the default minimum bet.
package poker_pkg;

   localparam logic [2:0] ACT_NO_ACTION = 3'b000;
   localparam logic [2:0] ACT_FOLD      = 3'b001;
   localparam logic [2:0] ACT_CHECK     = 3'b010;
   localparam logic [2:0] ACT_ALL_IN    = 3'b011;
   localparam logic [2:0] ACT_CALL      = 3'b100;
   localparam logic [2:0] ACT_BET       = 3'b110;
   localparam logic [2:0] ACT_RAISE     = 3'b111;

   localparam logic [7:0] MIN_BET_DEFAULT = 8'd2;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_REQUEST,
      ST_EVAL,
      ST_ACK,
      ST_REJECT,
      ST_DRAIN,
      ST_DONE
   } dac_state_e;

endpackage

// File: rtl/action_legality_check.sv
// Combinational legality/amount check of one bot action against the bot's
// stack and the amount owed; shared by the dealer collector and the bot.
module action_legality_check
   import poker_pkg::*;
#(
   parameter logic [7:0] MIN_BET = MIN_BET_DEFAULT
) (
   input  logic [2:0] action,
   input  logic [7:0] make_bet,
   input  logic [7:0] to_call,
   input  logic [7:0] money_left,
   output logic       legal,
   output logic [7:0] amount
);

   logic [8:0] raise_sum;

   // 9-bit sum so a raise that overflows 8 bits is rejected, not wrapped
   assign raise_sum = {1'b0, to_call} + {1'b0, make_bet};

   always_comb begin
      legal  = 1'b0;
      amount = '0;
      case (action)
         ACT_FOLD: legal = 1'b1;
         ACT_CHECK: legal = (to_call == '0);
         ACT_CALL: begin
            legal  = (to_call != '0) && (to_call <= money_left);
            amount = to_call;
         end
         ACT_BET: begin
            legal  = (to_call == '0) && (make_bet >= MIN_BET) && (make_bet <= money_left);
            amount = make_bet;
         end
         ACT_RAISE: begin
            legal  = (to_call != '0) && (make_bet >= MIN_BET) && (raise_sum <= {1'b0, money_left});
            amount = raise_sum[7:0];
         end
         ACT_ALL_IN: begin
            legal  = (money_left != '0);
            amount = money_left;
         end
         default: begin
            legal  = 1'b0;
            amount = '0;
         end
      endcase
   end

endmodule

// File: rtl/dealer_action_collector.sv
// Dealer-side action collector: requests an action from the bot, checks it,
// retries or force-folds, and reports one accepted action per turn.
module dealer_action_collector
   import poker_pkg::*;
#(
   parameter logic [7:0]  MIN_BET        = MIN_BET_DEFAULT,
   parameter int unsigned MAX_RETRIES    = 2,
   parameter int unsigned TIMEOUT_CYCLES = 1024,
   parameter int unsigned TW             = 11
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start_turn,
   input  logic       next_deal,
   input  logic [7:0] to_call,
   input  logic [7:0] money_left,
   input  logic       output_valid,
   input  logic [2:0] action,
   input  logic [7:0] make_bet,
   output logic       dealer_request_action,
   output logic       dealer_acknowledge,
   output logic       invalid_move,
   output logic       busy,
   output logic       result_valid,
   output logic [2:0] result_action,
   output logic [7:0] result_amount,
   output logic       timed_out
);

   localparam logic [TW-1:0] TOUT_LAST  = TW'(TIMEOUT_CYCLES - 1);
   localparam logic [2:0]    RETRY_LAST = 3'(MAX_RETRIES);

   dac_state_e    state_q, state_d;
   logic [TW-1:0] tout_q, tout_d;
   logic [2:0]    retry_q, retry_d, retry_inc;
   logic [7:0]    to_call_q, to_call_d, money_q, money_d;
   logic [2:0]    act_q, act_d;
   logic [7:0]    bet_q, bet_d, amount_q, amount_d;
   logic [2:0]    res_action_q, res_action_d;
   logic [7:0]    res_amount_q, res_amount_d;
   logic          res_to_q, res_to_d;
   logic          chk_legal;
   logic [7:0]    chk_amount;

   action_legality_check #(
      .MIN_BET (MIN_BET)
   ) u_check (
      .action     (act_q),
      .make_bet   (bet_q),
      .to_call    (to_call_q),
      .money_left (money_q),
      .legal      (chk_legal),
      .amount     (chk_amount)
   );

   assign retry_inc = retry_q + 3'd1;

   always_comb begin
      state_d      = state_q;
      tout_d       = tout_q;
      retry_d      = retry_q;
      to_call_d    = to_call_q;
      money_d      = money_q;
      act_d        = act_q;
      bet_d        = bet_q;
      amount_d     = amount_q;
      res_action_d = res_action_q;
      res_amount_d = res_amount_q;
      res_to_d     = res_to_q;
      // abort wins over everything and leaves the last result untouched
      if (next_deal) begin
         state_d = ST_IDLE;
         tout_d  = '0;
         retry_d = '0;
      end else begin
         case (state_q)
            ST_IDLE: if (start_turn) begin
               to_call_d = to_call;
               money_d   = money_left;
               retry_d   = '0;
               tout_d    = '0;
               state_d   = ST_REQUEST;
            end
            ST_REQUEST: begin
               tout_d = tout_q + 1'b1;
               if (output_valid) begin
                  act_d   = action;
                  bet_d   = make_bet;
                  state_d = ST_EVAL;
               end else if (tout_q == TOUT_LAST) begin
                  res_action_d = ACT_FOLD;
                  res_amount_d = '0;
                  res_to_d     = 1'b1;
                  state_d      = ST_DONE;
               end
            end
            ST_EVAL: begin
               amount_d = chk_amount;
               state_d  = chk_legal ? ST_ACK : ST_REJECT;
            end
            ST_ACK: if (!output_valid) begin
               res_action_d = act_q;
               res_amount_d = amount_q;
               res_to_d     = 1'b0;
               state_d      = ST_DONE;
            end
            ST_REJECT: begin
               retry_d = retry_inc;
               if (retry_inc == RETRY_LAST) begin
                  res_action_d = ACT_FOLD;
                  res_amount_d = '0;
                  res_to_d     = 1'b0;
                  state_d      = ST_DONE;
               end else begin
                  state_d = ST_DRAIN;
               end
            end
            ST_DRAIN: if (!output_valid) begin
               tout_d  = '0;
               state_d = ST_REQUEST;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= ST_IDLE;
         tout_q       <= '0;
         retry_q      <= '0;
         to_call_q    <= '0;
         money_q      <= '0;
         act_q        <= ACT_NO_ACTION;
         bet_q        <= '0;
         amount_q     <= '0;
         res_action_q <= ACT_NO_ACTION;
         res_amount_q <= '0;
         res_to_q     <= 1'b0;
      end else begin
         state_q      <= state_d;
         tout_q       <= tout_d;
         retry_q      <= retry_d;
         to_call_q    <= to_call_d;
         money_q      <= money_d;
         act_q        <= act_d;
         bet_q        <= bet_d;
         amount_q     <= amount_d;
         res_action_q <= res_action_d;
         res_amount_q <= res_amount_d;
         res_to_q     <= res_to_d;
      end
   end

   assign dealer_request_action = (state_q == ST_REQUEST);
   assign dealer_acknowledge    = (state_q == ST_ACK);
   assign invalid_move          = (state_q == ST_REJECT);
   assign busy                  = (state_q != ST_IDLE);
   assign result_valid          = (state_q == ST_DONE);
   assign result_action         = res_action_q;
   assign result_amount         = res_amount_q;
   assign timed_out             = res_to_q;

endmodule

// File: tb/tb_dealer_action_collector.sv
// Directed and randomized turns against dealer_action_collector, checked by a
// rule-table model of action legality and the handshake timing.
module tb_dealer_action_collector;

   localparam int MAX_R = 2;
   localparam int TOUT  = 16;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       start_turn = 1'b0, next_deal = 1'b0, output_valid = 1'b0;
   logic [7:0] to_call = '0, money_left = '0, make_bet = '0;
   logic [2:0] action = '0;
   logic       dealer_request_action, dealer_acknowledge, invalid_move, busy;
   logic       result_valid, timed_out;
   logic [2:0] result_action;
   logic [7:0] result_amount;

   int errors = 0;
   int checks = 0;

   logic [2:0] att_act [4];
   logic [7:0] att_bet [4];

   dealer_action_collector #(
      .MIN_BET        (8'd2),
      .MAX_RETRIES    (MAX_R),
      .TIMEOUT_CYCLES (TOUT),
      .TW             (5)
   ) dut (
      .clk                   (clk),
      .rst                   (rst),
      .start_turn            (start_turn),
      .next_deal             (next_deal),
      .to_call               (to_call),
      .money_left            (money_left),
      .output_valid          (output_valid),
      .action                (action),
      .make_bet              (make_bet),
      .dealer_request_action (dealer_request_action),
      .dealer_acknowledge    (dealer_acknowledge),
      .invalid_move          (invalid_move),
      .busy                  (busy),
      .result_valid          (result_valid),
      .result_action         (result_action),
      .result_amount         (result_amount),
      .timed_out             (timed_out)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Rule table: which actions are legal and how many chips move.
   function automatic void ref_eval(input int act, input int bet, input int tc, input int ml,
                                    output bit legal, output int amt);
      legal = 1'b0;
      amt   = 0;
      case (act)
         1: legal = 1'b1;
         2: legal = (tc == 0);
         3: begin legal = (ml > 0); amt = ml; end
         4: begin legal = (tc > 0) && (tc <= ml); amt = tc; end
         6: begin legal = (tc == 0) && (bet >= 2) && (bet <= ml); amt = bet; end
         7: begin legal = (tc > 0) && (bet >= 2) && (tc + bet <= ml); amt = tc + bet; end
         default: legal = 1'b0;
      endcase
   endfunction

   task automatic check_result(input string tag, input int act, input int amt, input bit to);
      chk({tag, "_rv"}, 32'(result_valid), 32'(1));
      chk({tag, "_act"}, 32'(result_action), 32'(act));
      chk({tag, "_amt"}, 32'(result_amount), 32'(amt));
      chk({tag, "_to"}, 32'(timed_out), 32'(to));
      chk({tag, "_req"}, 32'(dealer_request_action), 32'(0));
   endtask

   // One full turn: start, up to n bot attempts from att_act/att_bet, result.
   task automatic play_turn(input logic [7:0] tc, input logic [7:0] ml, input int n, input bit glitch);
      bit legal;
      int amt;
      int tries;
      bit done;
      logic [2:0] exp_act;
      @(negedge clk);
      start_turn = 1'b1; to_call = tc; money_left = ml;
      @(negedge clk);
      start_turn = 1'b0;
      chk("req_entry", 32'(dealer_request_action), 32'(1));
      chk("busy_entry", 32'(busy), 32'(1));
      if (glitch) begin
         start_turn = 1'b1; to_call = 8'd0; money_left = 8'hFF;
         @(negedge clk);
         start_turn = 1'b0;
         chk("req_glitch", 32'(dealer_request_action), 32'(1));
      end
      to_call = 8'($urandom); money_left = 8'($urandom);
      tries = 0;
      done  = 1'b0;
      for (int i = 0; i < n && !done; i++) begin
         repeat ($urandom_range(0, 3)) begin
            @(negedge clk);
            chk("req_wait", 32'(dealer_request_action), 32'(1));
         end
         output_valid = 1'b1; action = att_act[i]; make_bet = att_bet[i];
         exp_act = att_act[i];
         ref_eval(int'(att_act[i]), int'(att_bet[i]), int'(tc), int'(ml), legal, amt);
         @(negedge clk);
         chk("eval_quiet", 32'({dealer_request_action, dealer_acknowledge, invalid_move}), 32'(0));
         @(negedge clk);
         chk("ack", 32'(dealer_acknowledge), 32'(legal));
         chk("invalid", 32'(invalid_move), 32'(!legal));
         if (legal) begin
            repeat ($urandom_range(0, 2)) begin
               @(negedge clk);
               chk("ack_hold", 32'(dealer_acknowledge), 32'(1));
            end
            output_valid = 1'b0; action = 3'($urandom); make_bet = 8'($urandom);
            @(negedge clk);
            check_result("accept", int'(exp_act), amt, 1'b0);
            chk("accept_ack_drop", 32'(dealer_acknowledge), 32'(0));
            done = 1'b1;
         end else begin
            tries++;
            @(negedge clk);
            chk("invalid_pulse", 32'(invalid_move), 32'(0));
            if (tries == MAX_R) begin
               check_result("retry_fold", 1, 0, 1'b0);
               output_valid = 1'b0;
               done = 1'b1;
            end else begin
               chk("drain_req", 32'(dealer_request_action), 32'(0));
               repeat ($urandom_range(0, 2)) begin
                  @(negedge clk);
                  chk("drain_hold", 32'(dealer_request_action), 32'(0));
               end
               output_valid = 1'b0;
               @(negedge clk);
               chk("rerequest", 32'(dealer_request_action), 32'(1));
            end
         end
      end
      chk("turn_done", 32'(done), 32'(1));
      @(negedge clk);
      chk("idle_busy", 32'(busy), 32'(0));
      chk("idle_rv", 32'(result_valid), 32'(0));
   endtask

   initial begin
      // reset state
      repeat (2) @(negedge clk);
      chk("rst_outs", 32'({dealer_request_action, dealer_acknowledge, invalid_move, busy,
                           result_valid, timed_out}), 32'(0));
      chk("rst_act", 32'(result_action), 32'(0));
      chk("rst_amt", 32'(result_amount), 32'(0));
      rst = 1'b1;

      att_act[0] = 3'b110; att_bet[0] = 8'd10;                 // BET 10
      play_turn(8'd0, 8'd50, 1, 1'b0);
      att_act[0] = 3'b111; att_bet[0] = 8'd16;                 // RAISE 16 -> 20
      play_turn(8'd4, 8'd50, 1, 1'b1);
      att_act[0] = 3'b111; att_bet[0] = 8'd16;                 // short stack, then CALL
      att_act[1] = 3'b100; att_bet[1] = 8'd0;
      play_turn(8'd4, 8'd19, 2, 1'b0);
      att_act[0] = 3'b010; att_bet[0] = 8'd0;                  // CHECK twice -> forced FOLD
      att_act[1] = 3'b010; att_bet[1] = 8'd0;
      play_turn(8'd4, 8'd50, 2, 1'b0);
      att_act[0] = 3'b110; att_bet[0] = 8'd2;                  // minimum bet
      play_turn(8'd0, 8'd2, 1, 1'b0);
      att_act[0] = 3'b111; att_bet[0] = 8'd16;                 // raise to exactly the stack
      play_turn(8'd4, 8'd20, 1, 1'b0);
      att_act[0] = 3'b011; att_bet[0] = 8'd0;                  // ALL_IN with empty stack
      att_act[1] = 3'b101; att_bet[1] = 8'd0;                  // illegal code
      play_turn(8'd0, 8'd0, 2, 1'b0);
      att_act[0] = 3'b111; att_bet[0] = 8'd255;                // 9-bit overflow rejected
      att_act[1] = 3'b011; att_bet[1] = 8'd0;
      play_turn(8'd200, 8'd255, 2, 1'b0);

      // timeout: bot never answers
      @(negedge clk);
      start_turn = 1'b1; to_call = 8'd0; money_left = 8'd50;
      @(negedge clk);
      start_turn = 1'b0;
      chk("to_req_first", 32'(dealer_request_action), 32'(1));
      repeat (TOUT - 1) begin
         @(negedge clk);
         chk("to_req_hold", 32'({dealer_request_action, result_valid}), 32'(2));
      end
      @(negedge clk);
      check_result("timeout", 1, 0, 1'b1);
      @(negedge clk);
      chk("to_idle", 32'(busy), 32'(0));

      // next_deal during ACK
      @(negedge clk);
      start_turn = 1'b1; to_call = 8'd0; money_left = 8'd50;
      @(negedge clk);
      start_turn = 1'b0;
      output_valid = 1'b1; action = 3'b001; make_bet = 8'd0;
      repeat (2) @(negedge clk);
      chk("nd_ack", 32'(dealer_acknowledge), 32'(1));
      next_deal = 1'b1;
      @(negedge clk);
      next_deal = 1'b0;
      chk("nd_idle", 32'({busy, dealer_acknowledge, result_valid}), 32'(0));
      output_valid = 1'b0;
      repeat (3) begin
         @(negedge clk);
         chk("nd_no_result", 32'({busy, result_valid}), 32'(0));
      end
      att_act[0] = 3'b100; att_bet[0] = 8'd0;
      play_turn(8'd7, 8'd9, 1, 1'b0);

      // asynchronous reset in the middle of REQUEST
      @(negedge clk);
      start_turn = 1'b1; to_call = 8'd0; money_left = 8'd50;
      @(negedge clk);
      start_turn = 1'b0;
      chk("ar_req", 32'(dealer_request_action), 32'(1));
      #2 rst = 1'b0;
      #1;
      chk("ar_outs", 32'({dealer_request_action, dealer_acknowledge, invalid_move, busy,
                          result_valid, timed_out}), 32'(0));
      chk("ar_act", 32'(result_action), 32'(0));
      chk("ar_amt", 32'(result_amount), 32'(0));
      @(negedge clk);
      rst = 1'b1;
      output_valid = 1'b1; action = 3'b011; make_bet = 8'd0;
      repeat (4) begin
         @(negedge clk);
         chk("ar_ignored", 32'({busy, dealer_acknowledge, result_valid}), 32'(0));
      end
      output_valid = 1'b0;
      att_act[0] = 3'b011; att_bet[0] = 8'd0;
      play_turn(8'd10, 8'd30, 1, 1'b0);

      // randomized turns
      for (int t = 0; t < 40; t++) begin
         logic [7:0] tc, ml;
         tc = ($urandom_range(0, 1) == 0) ? 8'd0 : 8'($urandom_range(0, 60));
         ml = 8'($urandom_range(0, 80));
         for (int a = 0; a < MAX_R; a++) begin
            att_act[a] = 3'($urandom_range(0, 7));
            att_bet[a] = 8'($urandom_range(0, 40));
         end
         play_turn(tc, ml, MAX_R, 1'($urandom_range(0, 1)));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
